// File: rtl/output_merger_ee_check.sv
// Downstream of the four-wedge merger FSM: buffers merged words, passes data words,
// folds per-wedge end-event words into one merged EE word and tracks sync/overflow.
module output_merger_ee_check #(
    parameter int DATA_W = 21,
    parameter int TAG_W  = 8,
    parameter int ERR_W  = 8,
    parameter int WCNT_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              buf_we,
    input  logic              ee_comp_reg_ce,
    input  logic              out_we,
    input  logic              error_out,
    input  logic              clear_err,
    input  logic              fifo_out_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_we,
    output logic              lost_sync_reg,
    output logic              overflow_err,
    output logic [15:0]       event_count,
    output logic [WCNT_W-1:0] word_count
);

    localparam int SPARE_W = DATA_W - 3 - ERR_W - TAG_W;

    logic [DATA_W-1:0] buf_reg;
    logic [TAG_W-1:0]  ref_tag_reg, ref_tag_next;
    logic              ref_valid_reg, ref_valid_next;
    logic [ERR_W-1:0]  err_acc_reg, err_acc_next;
    logic              sync_bad_reg, sync_bad_next;

    logic [DATA_W-1:0] fifo_din_next;
    logic              fifo_we_next;
    logic              lost_sync_next, overflow_next;
    logic [15:0]       event_count_next;
    logic [WCNT_W-1:0] word_count_next;

    logic              buf_ee;
    logic [TAG_W-1:0]  buf_tag;
    logic [ERR_W-1:0]  buf_err;
    logic              wr_req, set_lost, set_ovf;

    assign buf_ee  = buf_reg[DATA_W-1];
    assign buf_tag = buf_reg[TAG_W-1:0];
    assign buf_err = buf_reg[TAG_W+ERR_W-1:TAG_W];

    always_comb begin
        ref_tag_next     = ref_tag_reg;
        ref_valid_next   = ref_valid_reg;
        err_acc_next     = err_acc_reg;
        sync_bad_next    = sync_bad_reg;
        fifo_din_next    = fifo_din;
        fifo_we_next     = 1'b0;
        event_count_next = event_count;
        word_count_next  = word_count;
        wr_req           = 1'b0;
        set_lost         = 1'b0;
        set_ovf          = 1'b0;

        // Compare stage runs first so a same-cycle emit sees its result.
        if (ee_comp_reg_ce && buf_ee) begin
            if (!ref_valid_reg) begin
                ref_tag_next   = buf_tag;
                err_acc_next   = buf_err;
                ref_valid_next = 1'b1;
            end else begin
                err_acc_next = err_acc_reg | buf_err;
                if (buf_tag != ref_tag_reg) begin
                    sync_bad_next = 1'b1;
                    set_lost      = 1'b1;
                end
            end
        end

        if (error_out) begin
            wr_req         = 1'b1;
            fifo_din_next  = {3'b111, {SPARE_W{1'b0}}, {ERR_W{1'b1}}, ref_tag_reg};
            ref_valid_next = 1'b0;
        end else if (out_we) begin
            wr_req = 1'b1;
            if (!buf_ee) begin
                fifo_din_next = buf_reg;
                if (word_count != {WCNT_W{1'b1}})
                    word_count_next = word_count + 1'b1;
            end else if (ref_valid_next) begin
                fifo_din_next    = {1'b1, sync_bad_next, 1'b0, {SPARE_W{1'b0}},
                                    err_acc_next, ref_tag_next};
                event_count_next = event_count + 16'd1;
                word_count_next  = '0;
                ref_valid_next   = 1'b0;
                err_acc_next     = '0;
                sync_bad_next    = 1'b0;
            end else begin
                // EE with no reference loaded: the wedges never reported this event.
                fifo_din_next = {2'b11, 1'b0, {SPARE_W{1'b0}}, {ERR_W{1'b1}}, {TAG_W{1'b0}}};
                set_lost      = 1'b1;
            end
        end

        if (wr_req) begin
            if (fifo_out_full) set_ovf = 1'b1;
            else               fifo_we_next = 1'b1;
        end

        lost_sync_next = set_lost | (lost_sync_reg & ~clear_err);
        overflow_next  = set_ovf  | (overflow_err  & ~clear_err);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_reg       <= '0;
            ref_tag_reg   <= '0;
            ref_valid_reg <= 1'b0;
            err_acc_reg   <= '0;
            sync_bad_reg  <= 1'b0;
            fifo_din      <= '0;
            fifo_we       <= 1'b0;
            lost_sync_reg <= 1'b0;
            overflow_err  <= 1'b0;
            event_count   <= '0;
            word_count    <= '0;
        end else begin
            if (buf_we) buf_reg <= data_in;
            ref_tag_reg   <= ref_tag_next;
            ref_valid_reg <= ref_valid_next;
            err_acc_reg   <= err_acc_next;
            sync_bad_reg  <= sync_bad_next;
            fifo_din      <= fifo_din_next;
            fifo_we       <= fifo_we_next;
            lost_sync_reg <= lost_sync_next;
            overflow_err  <= overflow_next;
            event_count   <= event_count_next;
            word_count    <= word_count_next;
        end
    end

endmodule

// File: tb/tb_output_merger_ee_check.sv
// Randomized scoreboard bench for output_merger_ee_check with a transaction-level model.
module tb_output_merger_ee_check;

    logic        clock = 1'b0;
    logic        reset;
    logic [20:0] data_in;
    logic        buf_we, ee_comp_reg_ce, out_we, error_out, clear_err, fifo_out_full;
    logic [20:0] fifo_din;
    logic        fifo_we, lost_sync_reg, overflow_err;
    logic [15:0] event_count;
    logic [11:0] word_count;

    output_merger_ee_check dut (
        .clock(clock), .reset(reset), .data_in(data_in), .buf_we(buf_we),
        .ee_comp_reg_ce(ee_comp_reg_ce), .out_we(out_we), .error_out(error_out),
        .clear_err(clear_err), .fifo_out_full(fifo_out_full), .fifo_din(fifo_din),
        .fifo_we(fifo_we), .lost_sync_reg(lost_sync_reg), .overflow_err(overflow_err),
        .event_count(event_count), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    logic [20:0] exp_q[$];

    // Model state
    int  exp_ev = 0;
    int  exp_wc = 0;
    bit  exp_lost = 0;
    bit  exp_ovf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clock) begin
        if (!reset && fifo_we) begin
            if (exp_q.size() == 0) begin
                failures++; checks++;
                $display("FAIL unexpected_write: got %h expected none at %0t", fifo_din, $time);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("fifo_word", {11'd0, fifo_din}, {11'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic write_expect(input logic [20:0] w, input bit full);
        if (full) exp_ovf = 1;
        else      exp_q.push_back(w);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_event_count"}, {16'd0, event_count}, exp_ev[15:0]);
        check({tag, "_word_count"},  {20'd0, word_count}, exp_wc);
        check({tag, "_lost_sync"},   {31'd0, lost_sync_reg}, {31'd0, exp_lost});
        check({tag, "_overflow"},    {31'd0, overflow_err}, {31'd0, exp_ovf});
    endtask

    task automatic send_data(input logic [19:0] d, input bit full);
        data_in = {1'b0, d}; buf_we = 1; tick(); buf_we = 0;
        out_we = 1; fifo_out_full = full;
        write_expect({1'b0, d}, full);
        if (exp_wc < 4095) exp_wc++;
        tick(); out_we = 0; fifo_out_full = 0;
    endtask

    // Event of n wedges: merged word is OR of errs, sync bit if any tag differs from wedge 0.
    task automatic run_event(input int n, input logic [31:0] tags, input logic [31:0] errs,
                             input bit fwd, input bit full);
        logic [7:0] err_or;
        bit bad;
        err_or = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            data_in = {1'b1, 4'b0, errs[i*8 +: 8], tags[i*8 +: 8]};
            buf_we = 1; tick(); buf_we = 0;
            err_or |= errs[i*8 +: 8];
            if (tags[i*8 +: 8] != tags[7:0]) begin bad = 1; exp_lost = 1; end
            ee_comp_reg_ce = 1;
            if (fwd && i == n - 1) begin
                out_we = 1; fifo_out_full = full;
            end
            tick(); ee_comp_reg_ce = 0;
            check("lost_after_strobe", {31'd0, lost_sync_reg}, {31'd0, exp_lost});
        end
        if (!(fwd)) begin
            out_we = 1; fifo_out_full = full; tick();
        end
        out_we = 0; fifo_out_full = 0;
        write_expect({1'b1, bad, 3'b000, err_or, tags[7:0]}, full);
        exp_ev++; exp_wc = 0;
    endtask

    task automatic do_clear();
        clear_err = 1; tick(); clear_err = 0;
        exp_lost = 0; exp_ovf = 0;
    endtask

    initial begin
        reset = 1; data_in = 0; buf_we = 0; ee_comp_reg_ce = 0; out_we = 0;
        error_out = 0; clear_err = 0; fifo_out_full = 0;
        #12;
        check("reset_fifo_din", {11'd0, fifo_din}, 32'd0);
        check("reset_fifo_we", {31'd0, fifo_we}, 32'd0);
        check_state("reset");
        @(posedge clock); #1; reset = 0; tick();

        // Data pass-through
        send_data(20'h00123, 0);
        send_data(20'h00456, 0);
        tick();
        check_state("data");

        // Clean event and event with a mismatched wedge 2
        run_event(4, 32'h5A5A5A5A, 32'h80000201, 0, 0);
        tick();
        check_state("event_ok");
        run_event(4, 32'h5A5B5A5A, 32'h80000201, 0, 0);
        send_data(20'h00777, 0);
        tick();
        check_state("lost_hold");
        do_clear();
        check_state("lost_clear");

        // Overflow on a full FIFO
        send_data(20'h00ABC, 1);
        tick();
        check_state("overflow");
        do_clear();
        check_state("ovf_clear");

        // Trailer wins over out_we
        data_in = {1'b1, 4'b0, 8'h04, 8'h33}; buf_we = 1; tick(); buf_we = 0;
        ee_comp_reg_ce = 1; tick(); ee_comp_reg_ce = 0;
        error_out = 1; out_we = 1;
        exp_q.push_back(21'h1CFF33);
        tick(); error_out = 0; out_we = 0;
        tick();
        check_state("trailer");

        // EE emitted with no reference loaded
        out_we = 1; exp_q.push_back(21'h18FF00); exp_lost = 1;
        tick(); out_we = 0; tick();
        check_state("no_ref");
        do_clear();

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                send_data(20'($urandom), ($urandom_range(0, 9) == 0));
            end else begin
                int n;
                logic [31:0] tags, errs;
                logic [7:0] t0;
                n = $urandom_range(1, 4);
                t0 = 8'($urandom);
                errs = $urandom;
                tags = 0;
                for (int i = 0; i < 4; i++)
                    tags[i*8 +: 8] = (i > 0 && $urandom_range(0, 7) == 0)
                                     ? t0 ^ 8'($urandom_range(1, 255)) : t0;
                run_event(n, tags, errs, $urandom_range(0, 1) == 1, ($urandom_range(0, 9) == 0));
            end
            tick();
            check_state("rand");
            if ($urandom_range(0, 5) == 0) do_clear();
        end
        do_clear();

        // Drive event_count to 0xFFFF at one event per cycle, then roll over
        data_in = {1'b1, 4'b0, 8'h00, 8'h11}; buf_we = 1; tick(); buf_we = 0;
        ee_comp_reg_ce = 1; out_we = 1; fifo_out_full = 1;
        repeat ((16'hFFFF - exp_ev[15:0]) & 16'hFFFF) tick();
        check("preset_ffff", {16'd0, event_count}, 32'h0000FFFF);
        tick();
        ee_comp_reg_ce = 0; out_we = 0; fifo_out_full = 0;
        exp_ev = 0; exp_wc = 0; exp_ovf = 1;
        check_state("rollover");

        // Reset in the middle of an event while a write is on the port
        data_in = {1'b1, 4'b0, 8'h01, 8'h22}; buf_we = 1; tick(); buf_we = 0;
        ee_comp_reg_ce = 1; tick(); ee_comp_reg_ce = 0;
        data_in = 21'h00999; buf_we = 1; tick(); buf_we = 0;
        out_we = 1; tick(); out_we = 0;
        check("pre_reset_we", {31'd0, fifo_we}, 32'd1);
        #2 reset = 1;
        #1;
        exp_ev = 0; exp_wc = 0; exp_lost = 0; exp_ovf = 0;
        check("async_fifo_din", {11'd0, fifo_din}, 32'd0);
        check("async_fifo_we", {31'd0, fifo_we}, 32'd0);
        check_state("async_reset");
        tick(); reset = 0; tick(); tick();

        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: got %0d pending words expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
